// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and its command-side driver:
// function codes and the driver FSM encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ZERO   = 3'd0;
  localparam logic [2:0] ALU_ONE    = 3'd1;
  localparam logic [2:0] ALU_PASS_A = 3'd2;
  localparam logic [2:0] ALU_PASS_B = 3'd3;
  localparam logic [2:0] ALU_ADD    = 3'd4;
  localparam logic [2:0] ALU_SUB    = 3'd5;
  localparam logic [2:0] ALU_AND    = 3'd6;
  localparam logic [2:0] ALU_OR     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_RESULT = 2'd2
  } drv_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: takes packed {A,B}, returns packed {B,C} with B echoed.
// Output is all-zero while disabled.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 en_i,
  input  logic [2:0]           ctl_i,
  input  logic [2*WIDTH-1:0]   ab_i,
  output logic [2*WIDTH-1:0]   bc_o
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;

  assign a = ab_i[2*WIDTH-1:WIDTH];
  assign b = ab_i[WIDTH-1:0];

  always_comb begin
    c = '0;
    case (ctl_i)
      ALU_ZERO:   c = '0;
      ALU_ONE:    c = WIDTH'(1);
      ALU_PASS_A: c = a;
      ALU_PASS_B: c = b;
      ALU_ADD:    c = a + b;
      ALU_SUB:    c = a - b;
      ALU_AND:    c = a & b;
      ALU_OR:     c = a | b;
      default:    c = '0;
    endcase
  end

  assign bc_o = en_i ? {b, c} : '0;

endmodule

// File: rtl/alu_driver.sv
// Command-side controller for the ALU: accepts an op, drives the ALU for
// SETTLE cycles, captures and echo-checks the result, then hands it out.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [2:0]           op_ctl_i,
  input  logic [WIDTH-1:0]     op_a_i,
  input  logic [WIDTH-1:0]     op_b_i,
  input  logic                 op_chain_i,
  output logic                 alu_en_o,
  output logic [2:0]           alu_ctl_o,
  output logic [2*WIDTH-1:0]   alu_ab_o,
  input  logic [2*WIDTH-1:0]   alu_bc_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [WIDTH-1:0]     res_c_o,
  output logic                 res_err_o,
  output logic [7:0]           res_cnt_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  drv_state_e       state_q, state_d;
  logic [3:0]       cnt_q;
  logic [2:0]       ctl_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, c_q;
  logic             err_q;
  logic [7:0]       res_cnt_q;
  logic             accept, capture, done;

  assign accept  = (state_q == ST_IDLE)   && op_valid_i;
  assign capture = (state_q == ST_DRIVE)  && (cnt_q == 4'd0);
  assign done    = (state_q == ST_RESULT) && res_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (op_valid_i)     state_d = ST_DRIVE;
      ST_DRIVE:  if (cnt_q == 4'd0)  state_d = ST_RESULT;
      ST_RESULT: if (res_ready_i)    state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      acc_q     <= '0;
      c_q       <= '0;
      err_q     <= 1'b0;
      res_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= SETTLE_LOAD;
      else if ((state_q == ST_DRIVE) && (cnt_q != 4'd0))
        cnt_q <= cnt_q - 4'd1;
      // acc follows every capture, even when the echo check fails
      if (capture) begin
        c_q   <= alu_bc_i[WIDTH-1:0];
        acc_q <= alu_bc_i[WIDTH-1:0];
        err_q <= (alu_bc_i[2*WIDTH-1:WIDTH] != b_q);
      end
      if (done)
        res_cnt_q <= res_cnt_q + 8'd1;
    end
  end

  // Operand latches only matter while in DRIVE, so they carry no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ctl_q <= op_ctl_i;
      b_q   <= op_b_i;
      a_q   <= op_chain_i ? acc_q : op_a_i;
    end
  end

  assign op_ready_o  = (state_q == ST_IDLE);
  assign alu_en_o    = (state_q == ST_DRIVE);
  assign alu_ctl_o   = alu_en_o ? ctl_q : 3'd0;
  assign alu_ab_o    = alu_en_o ? {a_q, b_q} : '0;
  assign res_valid_o = (state_q == ST_RESULT);
  assign res_c_o     = c_q;
  assign res_err_o   = err_q;
  assign res_cnt_o   = res_cnt_q;

endmodule
